// File: rtl/game_flow_controller_pkg.sv
// Shared definitions for the pong game-flow block: state codes, field widths
// and default tuning values used by the menu, renderer and flow controller.
package game_flow_controller_pkg;

    localparam int unsigned STATE_W              = 3;
    localparam int unsigned SCORE_W              = 4;
    localparam int unsigned SERVE_CNT_W          = 8;
    localparam int unsigned WIN_SCORE_DEFAULT    = 7;
    localparam int unsigned SERVE_FRAMES_DEFAULT = 120;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Per-game context carried alongside the state register
    typedef struct packed {
        logic [SERVE_CNT_W-1:0] serve_cnt;
        logic [SCORE_W-1:0]     score_left;
        logic [SCORE_W-1:0]     score_right;
        logic                   winner;
        state_t                 resume_state;
    } game_ctx_t;

    localparam game_ctx_t CTX_RESET = '{
        serve_cnt:    '0,
        score_left:   '0,
        score_right:  '0,
        winner:       1'b0,
        resume_state: ST_SERVE
    };

endpackage

// File: rtl/game_flow_controller_edge_detect.sv
// 1-bit rising-edge detector; prev resets high so a level held through
// reset never looks like a fresh press.
module game_flow_controller_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic sig,
    output logic rise_c
);

    logic prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sig;
        end
    end

    assign rise_c = sig & ~prev_q;

endmodule

// File: rtl/game_flow_controller.sv
// Pong game-flow FSM: menu, serve countdown, play, pause menu and game-over,
// with score keeping and registered control outputs.
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = WIN_SCORE_DEFAULT,
    parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_select,
    input  logic               btn_pause,
    input  logic               pause_action,
    input  logic               point_left,
    input  logic               point_right,
    output logic [STATE_W-1:0] state,
    output logic               game_run,
    output logic               ball_reset,
    output logic               pause_menu_enable,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               winner
);

    localparam logic [SCORE_W-1:0]     WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [SERVE_CNT_W-1:0] SERVE_VAL = SERVE_CNT_W'(SERVE_FRAMES);

    state_t    state_q, state_d;
    game_ctx_t ctx_q, ctx_d;
    logic      game_run_q, ball_reset_q, pause_menu_q;
    logic      game_run_d, ball_reset_d, pause_menu_d;
    logic      sel_rise_c, pause_rise_c;
    logic [SCORE_W-1:0] left_inc_c, right_inc_c;

    game_flow_controller_edge_detect u_sel_edge (
        .clock  (clock),
        .reset  (reset),
        .sig    (btn_select),
        .rise_c (sel_rise_c)
    );

    game_flow_controller_edge_detect u_pause_edge (
        .clock  (clock),
        .reset  (reset),
        .sig    (btn_pause),
        .rise_c (pause_rise_c)
    );

    // Saturating increments keep scores from ever passing the win value
    assign left_inc_c  = (ctx_q.score_left  < WIN_VAL) ? ctx_q.score_left  + SCORE_W'(1)
                                                        : ctx_q.score_left;
    assign right_inc_c = (ctx_q.score_right < WIN_VAL) ? ctx_q.score_right + SCORE_W'(1)
                                                        : ctx_q.score_right;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ctx_q        <= CTX_RESET;
            game_run_q   <= 1'b0;
            ball_reset_q <= 1'b0;
            pause_menu_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctx_q        <= ctx_d;
            game_run_q   <= game_run_d;
            ball_reset_q <= ball_reset_d;
            pause_menu_q <= pause_menu_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_rise_c) begin
                    state_d           = ST_SERVE;
                    ctx_d.score_left  = '0;
                    ctx_d.score_right = '0;
                    ctx_d.winner      = 1'b0;
                    ctx_d.serve_cnt   = '0;
                end
            end
            ST_SERVE: begin
                if (pause_rise_c) begin
                    state_d            = ST_PAUSE;
                    ctx_d.resume_state = ST_SERVE;
                end else if (frame_tick) begin
                    ctx_d.serve_cnt = ctx_q.serve_cnt + SERVE_CNT_W'(1);
                    if (ctx_d.serve_cnt == SERVE_VAL) begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                // Left takes priority on a tie; any point beats a pause press
                if (point_left) begin
                    ctx_d.score_left = left_inc_c;
                    if (left_inc_c == WIN_VAL) begin
                        state_d      = ST_OVER;
                        ctx_d.winner = 1'b0;
                    end else begin
                        state_d         = ST_SERVE;
                        ctx_d.serve_cnt = '0;
                    end
                end else if (point_right) begin
                    ctx_d.score_right = right_inc_c;
                    if (right_inc_c == WIN_VAL) begin
                        state_d      = ST_OVER;
                        ctx_d.winner = 1'b1;
                    end else begin
                        state_d         = ST_SERVE;
                        ctx_d.serve_cnt = '0;
                    end
                end else if (pause_rise_c) begin
                    state_d            = ST_PAUSE;
                    ctx_d.resume_state = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (sel_rise_c) begin
                    state_d = pause_action ? ST_IDLE : ctx_q.resume_state;
                end else if (pause_rise_c) begin
                    state_d = ctx_q.resume_state;
                end
            end
            ST_OVER: begin
                if (sel_rise_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs follow the next state so they change on the same edge as state
    always_comb begin
        game_run_d   = 1'b0;
        pause_menu_d = 1'b0;
        ball_reset_d = 1'b0;
        game_run_d   = (state_d == ST_PLAY);
        pause_menu_d = (state_d == ST_PAUSE);
        ball_reset_d = (state_d == ST_SERVE) &&
                       ((state_q == ST_IDLE) || (state_q == ST_PLAY));
    end

    assign state             = state_q;
    assign game_run          = game_run_q;
    assign ball_reset        = ball_reset_q;
    assign pause_menu_enable = pause_menu_q;
    assign score_left        = ctx_q.score_left;
    assign score_right       = ctx_q.score_right;
    assign winner            = ctx_q.winner;

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller: directed stimulus queues the
// expected output snapshot, a negedge monitor pops and compares it.
module tb_game_flow_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_select = 1'b0;
    logic       btn_pause = 1'b0;
    logic       pause_action = 1'b0;
    logic       point_left = 1'b0;
    logic       point_right = 1'b0;
    logic [2:0] state;
    logic       game_run;
    logic       ball_reset;
    logic       pause_menu_enable;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       winner;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    typedef struct packed {
        logic [2:0] st;
        logic       run;
        logic       br;
        logic       pm;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       w;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    game_flow_controller dut (
        .clock             (clock),
        .reset             (reset),
        .frame_tick        (frame_tick),
        .btn_select        (btn_select),
        .btn_pause         (btn_pause),
        .pause_action      (pause_action),
        .point_left        (point_left),
        .point_right       (point_right),
        .state             (state),
        .game_run          (game_run),
        .ball_reset        (ball_reset),
        .pause_menu_enable (pause_menu_enable),
        .score_left        (score_left),
        .score_right       (score_right),
        .winner            (winner)
    );

    always #5 clock = ~clock;

    // Monitor: compare every queued expectation against the settled outputs
    always @(negedge clock) begin
        obs_t  e;
        obs_t  a;
        string n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = '{st: state, run: game_run, br: ball_reset, pm: pause_menu_enable,
                  sl: score_left, sr: score_right, w: winner};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got st=%0d run=%0b br=%0b pm=%0b sl=%0d sr=%0d w=%0b, want st=%0d run=%0b br=%0b pm=%0b sl=%0d sr=%0d w=%0b",
                         n, a.st, a.run, a.br, a.pm, a.sl, a.sr, a.w,
                         e.st, e.run, e.br, e.pm, e.sl, e.sr, e.w);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic exp(input string n, input logic [2:0] st, input logic run,
                       input logic br, input logic pm, input logic [3:0] sl,
                       input logic [3:0] sr, input logic w);
        obs_t e;
        e = '{st: st, run: run, br: br, pm: pm, sl: sl, sr: sr, w: w};
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) cyc();
        frame_tick = 1'b0;
    endtask

    task automatic press_select(input logic action);
        pause_action = action;
        btn_select   = 1'b1;
        cyc();
        btn_select   = 1'b0;
    endtask

    task automatic press_pause();
        btn_pause = 1'b1;
        cyc();
        btn_pause = 1'b0;
    endtask

    task automatic point(input logic pl, input logic pr);
        point_left  = pl;
        point_right = pr;
        cyc();
        point_left  = 1'b0;
        point_right = 1'b0;
    endtask

    // Score a non-winning point from PLAY, then run the full serve back to PLAY
    task automatic score_and_serve(input string n, input logic pl, input logic pr,
                                   input logic [3:0] sl, input logic [3:0] sr);
        point(pl, pr);
        exp(n, S_SERVE, 1'b0, 1'b1, 1'b0, sl, sr, 1'b0);
        ticks(120);
        exp({n, "_replay"}, S_PLAY, 1'b1, 1'b0, 1'b0, sl, sr, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with select held: no edge may appear after release
        reset      = 1'b1;
        btn_select = 1'b1;
        idle(3);
        exp("reset", S_IDLE, 0, 0, 0, 4'd0, 4'd0, 0);
        reset = 1'b0;
        idle(2);
        exp("held_through_reset", S_IDLE, 0, 0, 0, 4'd0, 4'd0, 0);
        btn_select = 1'b0;
        cyc();
        exp("release_select", S_IDLE, 0, 0, 0, 4'd0, 4'd0, 0);

        press_select(1'b0);
        exp("idle_to_serve", S_SERVE, 0, 1, 0, 4'd0, 4'd0, 0);
        cyc();
        exp("ball_reset_one_cycle", S_SERVE, 0, 0, 0, 4'd0, 4'd0, 0);
        ticks(119);
        exp("serve_119_ticks", S_SERVE, 0, 0, 0, 4'd0, 4'd0, 0);
        ticks(1);
        exp("serve_to_play", S_PLAY, 1, 0, 0, 4'd0, 4'd0, 0);

        // Build to 2/3, then a simultaneous point credits left only
        score_and_serve("left_1_0",  1, 0, 4'd1, 4'd0);
        score_and_serve("left_2_0",  1, 0, 4'd2, 4'd0);
        score_and_serve("right_2_1", 0, 1, 4'd2, 4'd1);
        score_and_serve("right_2_2", 0, 1, 4'd2, 4'd2);
        score_and_serve("right_2_3", 0, 1, 4'd2, 4'd3);
        score_and_serve("both_3_3",  1, 1, 4'd3, 4'd3);
        score_and_serve("left_4_3",  1, 0, 4'd4, 4'd3);
        score_and_serve("left_5_3",  1, 0, 4'd5, 4'd3);
        score_and_serve("left_6_3",  1, 0, 4'd6, 4'd3);
        point(1, 0);
        exp("left_wins", S_OVER, 0, 0, 0, 4'd7, 4'd3, 0);

        // OVER ignores points and pause; scores hold into IDLE
        point(0, 1);
        exp("over_ignores_point", S_OVER, 0, 0, 0, 4'd7, 4'd3, 0);
        press_pause();
        exp("over_ignores_pause", S_OVER, 0, 0, 0, 4'd7, 4'd3, 0);
        idle(1);
        press_select(1'b0);
        exp("over_to_idle", S_IDLE, 0, 0, 0, 4'd7, 4'd3, 0);
        idle(1);
        press_select(1'b0);
        exp("new_game_clears", S_SERVE, 0, 1, 0, 4'd0, 4'd0, 0);

        // Pause mid-serve freezes the counter
        ticks(50);
        exp("serve_50", S_SERVE, 0, 0, 0, 4'd0, 4'd0, 0);
        press_pause();
        exp("serve_to_pause", S_PAUSE, 0, 0, 1, 4'd0, 4'd0, 0);
        ticks(10);
        exp("pause_ignores_ticks", S_PAUSE, 0, 0, 1, 4'd0, 4'd0, 0);
        point(1, 0);
        exp("pause_ignores_point", S_PAUSE, 0, 0, 1, 4'd0, 4'd0, 0);
        press_select(1'b0);
        exp("continue_to_serve", S_SERVE, 0, 0, 0, 4'd0, 4'd0, 0);
        ticks(69);
        exp("resumed_serve_69", S_SERVE, 0, 0, 0, 4'd0, 4'd0, 0);
        ticks(1);
        exp("resumed_serve_to_play", S_PLAY, 1, 0, 0, 4'd0, 4'd0, 0);

        // Pause toggled from PLAY, then quit to the start menu
        press_pause();
        exp("play_to_pause", S_PAUSE, 0, 0, 1, 4'd0, 4'd0, 0);
        idle(1);
        press_pause();
        exp("pause_toggle_to_play", S_PLAY, 1, 0, 0, 4'd0, 4'd0, 0);
        score_and_serve("right_0_1", 0, 1, 4'd0, 4'd1);
        press_pause();
        exp("play_to_pause_2", S_PAUSE, 0, 0, 1, 4'd0, 4'd1, 0);
        idle(1);
        press_select(1'b1);
        exp("pause_quit_to_idle", S_IDLE, 0, 0, 0, 4'd0, 4'd1, 0);
        idle(1);
        press_select(1'b0);
        exp("restart_serve", S_SERVE, 0, 1, 0, 4'd0, 4'd0, 0);

        // Point and pause edge together: the point wins
        ticks(120);
        exp("play_again", S_PLAY, 1, 0, 0, 4'd0, 4'd0, 0);
        btn_pause  = 1'b1;
        point_left = 1'b1;
        cyc();
        btn_pause  = 1'b0;
        point_left = 1'b0;
        exp("point_beats_pause", S_SERVE, 0, 1, 0, 4'd1, 4'd0, 0);
        idle(1);

        // Reset overrides a held pause mid-PAUSE
        ticks(30);
        press_pause();
        exp("pause_before_reset", S_PAUSE, 0, 0, 1, 4'd1, 4'd0, 0);
        idle(1);
        reset     = 1'b1;
        btn_pause = 1'b1;
        cyc();
        exp("reset_mid_pause", S_IDLE, 0, 0, 0, 4'd0, 4'd0, 0);
        reset = 1'b0;
        cyc();
        exp("after_reset_idle", S_IDLE, 0, 0, 0, 4'd0, 4'd0, 0);
        btn_pause = 1'b0;
        idle(1);

        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
